// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and receiver lock state
package vga_pkg;
  localparam int DIV = 4;
  localparam int H_TOTAL = 800;
  localparam int H_SYNC = 96;
  localparam int H_OFFSET = 144;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC = 2;
  localparam int V_OFFSET = 35;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} rx_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus edge register with rise/fall pulses
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;
  // reset to the idle-high level of an active-low sync so release is quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= 3'b111;
    else sr <= {sr[1:0], d};
  end
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel tick/coordinates from VGA syncs, checks timing and
// emits a pixel-valid stream once locked.
module vga_sync_rx #(
  parameter int DIV = vga_pkg::DIV,
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_OFFSET = vga_pkg::H_OFFSET,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_TOTAL = vga_pkg::V_TOTAL,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_OFFSET = vga_pkg::V_OFFSET,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  p_x,
  output logic [9:0]  p_y,
  output logic [11:0] rgb_out,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_cnt
);
  import vga_pkg::*;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  rx_state_t state, state_n;
  logic h_rise, h_fall, v_rise, v_fall, tick, h_bad, v_bad, err_seen, act;
  logic [TW-1:0] tick_cnt;
  logic [10:0] h_cnt, h_nxt;
  logic [9:0] v_cnt, v_nxt;
  logic [2:0][11:0] rgb_d;
  logic [8:0] err_sum;
  sync_edge_det u_hs (.clk(clk), .rst(rst), .d(hSync), .rise(h_rise), .fall(h_fall));
  sync_edge_det u_vs (.clk(clk), .rst(rst), .d(vSync), .rise(v_rise), .fall(v_fall));
  // the last pixel's tick coincides with the next sync edge, so checks use the count including it
  assign tick = tick_cnt == TW'(DIV - 1);
  assign h_nxt = (tick && h_cnt != 11'h7ff) ? h_cnt + 11'd1 : h_cnt;
  assign v_nxt = (h_fall && v_cnt != 10'h3ff) ? v_cnt + 10'd1 : v_cnt;
  assign h_bad = (h_fall && h_nxt != 11'(H_TOTAL)) || (h_rise && h_nxt != 11'(H_SYNC)) ||
                 (!h_fall && tick && h_cnt == 11'(2 * H_TOTAL - 1));
  assign v_bad = (v_fall && v_nxt != 10'(V_TOTAL)) || (v_rise && v_nxt != 10'(V_SYNC));
  assign act = tick && h_cnt >= 11'(H_OFFSET) && h_cnt < 11'(H_OFFSET + H_ACTIVE) &&
               v_cnt >= 10'(V_OFFSET) && v_cnt < 10'(V_OFFSET + V_ACTIVE);
  assign err_sum = {1'b0, err_cnt} + 9'(h_bad) + 9'(v_bad);
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    state_n = state == SEARCH ? (v_fall ? CHECK : SEARCH)
            : state == CHECK  ? ((v_fall && !err_seen && !h_bad && !v_bad) ? LOCKED : CHECK)
            : ((h_bad || v_bad) ? SEARCH : LOCKED);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEARCH;
      err_seen <= 1'b0;
      tick_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      rgb_d <= '0;
      h_err <= 1'b0;
      v_err <= 1'b0;
      frame_start <= 1'b0;
      err_cnt <= '0;
      pix_valid <= 1'b0;
      p_x <= '0;
      p_y <= '0;
      rgb_out <= '0;
    end else begin
      state <= state_n;
      err_seen <= v_fall ? 1'b0 : err_seen | h_bad | v_bad;
      tick_cnt <= (h_fall || tick) ? '0 : tick_cnt + TW'(1);
      h_cnt <= h_fall ? '0 : h_nxt;
      v_cnt <= v_fall ? '0 : v_nxt;
      rgb_d <= {rgb_d[1:0], rgb_in};
      h_err <= h_bad;
      v_err <= v_bad;
      frame_start <= v_fall;
      err_cnt <= err_sum[8] ? 8'hff : err_sum[7:0];
      pix_valid <= act && locked;
      if (act && locked) begin
        p_x <= 10'(h_cnt - 11'(H_OFFSET));
        p_y <= v_cnt - 10'(V_OFFSET);
        rgb_out <= rgb_d[2];
      end
    end
  end
endmodule
